// File: rtl/zigbee_pkg.sv
// Shared definitions for the 802.15.4 2.4 GHz O-QPSK PHY.
// CHIP_TABLE holds one 32-chip PN word per 4-bit symbol, with chip c0 at bit 0.
package zigbee_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [31:0] CHIP_TABLE [16] = '{
    32'h744AC39B, 32'h44AC39B7, 32'h4AC39B74, 32'hAC39B744,
    32'hC39B744A, 32'h39B744AC, 32'h9B744AC3, 32'hB744AC39,
    32'hDEE06931, 32'hEE06931D, 32'hE06931DE, 32'h06931DEE,
    32'h6931DEE0, 32'h931DEE06, 32'h31DEE069, 32'h1DEE0693
  };

endpackage

// File: rtl/dsss_spreader.sv
// DSSS spreader: packs serial bits into nibbles and emits the matching
// 32-chip PN sequence one chip per chip_en, back-to-back when data keeps up.
module dsss_spreader
  import zigbee_pkg::*;
#(
  parameter int CHIPS_PER_SYM = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_in,
  input  logic bit_en,
  input  logic chip_en,
  input  logic clr_flags,
  output logic chip_out,
  output logic chip_valid,
  output logic sym_start,
  output logic busy,
  output logic overrun,
  output logic underrun
);

  localparam int CW = $clog2(CHIPS_PER_SYM);
  localparam logic [CW-1:0] LAST_CHIP = CW'(CHIPS_PER_SYM - 1);

  logic [1:0]    bit_cnt_q;
  logic [2:0]    nib_q;
  logic [3:0]    pend_q;
  logic          pend_vld_q;
  state_e        state_q, state_d;
  logic [31:0]   shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          chip_q, chip_d;
  logic          cv_q, cv_d;
  logic          ss_q, ss_d;
  logic          ovr_q, ovr_d;
  logic          unf_q, unf_d;
  logic          unf_set;

  logic       last_chip, consume, nib_done, drop;
  logic [3:0] new_nib;

  assign last_chip = (state_q == ST_RUN) && chip_en && (cnt_q == LAST_CHIP);
  assign consume   = pend_vld_q && ((state_q == ST_IDLE) || last_chip);
  assign nib_done  = bit_en && (bit_cnt_q == 2'd3);
  assign new_nib   = {bit_in, nib_q};
  // A finished nibble may only overwrite the pending slot if it empties this cycle.
  assign drop      = nib_done && pend_vld_q && !consume;

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q <= '0;
      nib_q     <= '0;
    end else if (bit_en) begin
      bit_cnt_q <= bit_cnt_q + 2'd1;
      case (bit_cnt_q)
        2'd0:    nib_q[0] <= bit_in;
        2'd1:    nib_q[1] <= bit_in;
        2'd2:    nib_q[2] <= bit_in;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else if (nib_done && !drop) begin
      pend_q     <= new_nib;
      pend_vld_q <= 1'b1;
    end else if (consume) begin
      pend_vld_q <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    chip_d  = chip_q;
    cv_d    = 1'b0;
    ss_d    = 1'b0;
    unf_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_vld_q) begin
          state_d = ST_RUN;
          shreg_d = CHIP_TABLE[pend_q];
          cnt_d   = '0;
        end
      end
      default: begin
        if (chip_en) begin
          chip_d  = shreg_q[0];
          cv_d    = 1'b1;
          ss_d    = (cnt_q == '0);
          shreg_d = shreg_q >> 1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_CHIP) begin
            // Reload in place so the next chip_en starts the new symbol with no gap.
            if (pend_vld_q) begin
              shreg_d = CHIP_TABLE[pend_q];
              cnt_d   = '0;
            end else begin
              state_d = ST_IDLE;
              unf_set = 1'b1;
            end
          end
        end
      end
    endcase
  end

  assign ovr_d = drop    | (ovr_q & ~clr_flags);
  assign unf_d = unf_set | (unf_q & ~clr_flags);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      chip_q  <= 1'b0;
      cv_q    <= 1'b0;
      ss_q    <= 1'b0;
      ovr_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      chip_q  <= chip_d;
      cv_q    <= cv_d;
      ss_q    <= ss_d;
      ovr_q   <= ovr_d;
      unf_q   <= unf_d;
    end
  end

  assign chip_out   = chip_q;
  assign chip_valid = cv_q;
  assign sym_start  = ss_q;
  assign busy       = (state_q == ST_RUN);
  assign overrun    = ovr_q;
  assign underrun   = unf_q;

endmodule
